rs_encode_stream: RTL and testbench

// - Systematic Reed-Solomon encoder over GF(2^8). It is the transmit-side counterpart of the correct_errors decoder.
// - Accepts a byte-serial message framed by start/last_in.
// - Re-emits the message unchanged, then appends NSYM parity bytes from an LFSR remainder of division by g(x).
// - Output stream format: message bytes first, then parity, MSB-coefficient first. This matches the decoder's codeword input.

---
 rtl/rs_encode_stream_if.sv | 49 ++++
 rtl/rs_encode_stream.sv | 192 +++++++++++++++++++
 tb/tb_rs_encode_stream.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rs_encode_stream_if.sv
// rtl/rs_encode_stream_if.sv - byte-stream bundle between a message source and rs_encode_stream
//
// Purpose : groups the start/message handshake and the codeword output of the
//           Reed-Solomon encoder so both sides connect through one port.
// Signals : start        source -> encoder  begin a new codeword (taken in IDLE only)
//           msg_in[7:0]  source -> encoder  message byte
//           valid_in     source -> encoder  msg_in valid
//           last_in      source -> encoder  accepted byte is the final message byte
//           ready_in     encoder -> source  encoder accepts a byte this cycle
//           codeword_out encoder -> sink    message byte or parity byte
//           valid_out    encoder -> sink    codeword_out valid
//           done         encoder -> sink    one-cycle pulse after the last parity byte
//           busy         encoder -> sink    encoder not idle
//           overflow     encoder -> sink    only with RS_ENC_OVERFLOW_EN: forced end seen
// Macro   : RS_ENC_OVERFLOW_EN adds the overflow signal.
interface rs_encode_stream_if;
   logic       start;
   logic [7:0] msg_in;
   logic       valid_in;
   logic       last_in;
   logic       ready_in;
   logic [7:0] codeword_out;
   logic       valid_out;
   logic       done;
   logic       busy;
`ifdef RS_ENC_OVERFLOW_EN
   logic       overflow;

   modport master (
      output start, msg_in, valid_in, last_in,
      input  ready_in, codeword_out, valid_out, done, busy, overflow
   );

   modport slave (
      input  start, msg_in, valid_in, last_in,
      output ready_in, codeword_out, valid_out, done, busy, overflow
   );
`else
   modport master (
      output start, msg_in, valid_in, last_in,
      input  ready_in, codeword_out, valid_out, done, busy
   );

   modport slave (
      input  start, msg_in, valid_in, last_in,
      output ready_in, codeword_out, valid_out, done, busy
   );
`endif
endinterface

// File: rtl/rs_encode_stream.sv
// rtl/rs_encode_stream.sv - systematic Reed-Solomon encoder over GF(2^8), byte-serial stream
//
// Purpose : re-emits a framed message unchanged, then appends NSYM parity bytes
//           (remainder of m(x)*x^NSYM divided by g(x)), highest coefficient first.
//           g(x) = prod_{i=0..NSYM-1} (x + alpha^i), alpha = 2, built at elaboration.
// Ports   : clk    rising-edge clock
//           rst_n  asynchronous active-low reset
//           bus    rs_encode_stream_if.slave (start/msg_in/valid_in/last_in in,
//                  ready_in/codeword_out/valid_out/done/busy out, overflow optional)
// Macro   : RS_ENC_OVERFLOW_EN adds bus.overflow, set one cycle after a message
//           is cut at MAX_CW-NSYM bytes without last_in, cleared by the next start.
module rs_encode_stream #(
   parameter int         NSYM   = 7,
   parameter int         MAX_CW = 32,
   parameter logic [8:0] PRIM   = 9'h11D
) (
   input  logic               clk,
   input  logic               rst_n,
   rs_encode_stream_if.slave  bus
);

   localparam int         MAX_MSG  = MAX_CW - NSYM;
   localparam logic [5:0] MSG_LAST = 6'(MAX_MSG);
   localparam int         PW       = (NSYM > 1) ? $clog2(NSYM) : 1;
   localparam logic [PW-1:0] PAR_LAST = PW'(NSYM - 1);

   // GF(2^8) multiply: shift-and-add with reduction by PRIM whenever bit 7 shifts out.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] s;
      p = 8'h00;
      s = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ s;
         s = s[7] ? ((s << 1) ^ PRIM[7:0]) : (s << 1);
      end
      return p;
   endfunction

   // Generator coefficients g[k] of x^k, k = 0..NSYM-1 (the monic x^NSYM term is implicit).
   function automatic logic [NSYM-1:0][7:0] gen_poly();
      logic [NSYM:0][7:0] g;
      logic [7:0]         root;
      g    = '0;
      g[0] = 8'h01;
      root = 8'h01;
      for (int i = 0; i < NSYM; i++) begin
         // multiply by (x + root); walking downward keeps g[k-1] at its old value
         for (int k = NSYM; k >= 1; k--) begin
            g[k] = g[k-1] ^ gf_mul(g[k], root);
         end
         g[0] = gf_mul(g[0], root);
         root = gf_mul(root, 8'h02);
      end
      return g[NSYM-1:0];
   endfunction

   localparam logic [NSYM-1:0][7:0] G = gen_poly();

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD   = 2'd1,
      S_PARITY = 2'd2,
      S_FIN    = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [NSYM-1:0][7:0]  r_lfsr;
   logic [NSYM-1:0][7:0]  w_lfsr_upd;
   logic [5:0]            r_count;
   logic [PW-1:0]         r_par_cnt;
   logic [7:0]            r_cw;
   logic                  r_valid;
   logic                  r_done;
   logic                  w_ready;
   logic                  w_busy;
   logic                  w_accept;
   logic                  w_end_msg;
   logic [7:0]            w_fb;
`ifdef RS_ENC_OVERFLOW_EN
   logic                  r_overflow;
   logic                  w_forced;
`endif

   assign w_accept  = (r_state == S_LOAD) && bus.valid_in;
   // the 25th accepted byte closes the message whether or not last_in is set
   assign w_end_msg = w_accept && (bus.last_in || (r_count == MSG_LAST - 6'd1));
   assign w_fb      = bus.msg_in ^ r_lfsr[NSYM-1];
`ifdef RS_ENC_OVERFLOW_EN
   assign w_forced  = w_accept && !bus.last_in && (r_count == MSG_LAST - 6'd1);
`endif

   // LFSR step for one accepted message byte
   always_comb begin
      w_lfsr_upd    = '0;
      w_lfsr_upd[0] = gf_mul(w_fb, G[0]);
      for (int i = 1; i < NSYM; i++) begin
         w_lfsr_upd[i] = r_lfsr[i-1] ^ gf_mul(w_fb, G[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      w_ready = 1'b0;
      w_busy  = 1'b1;
      case (r_state)
         S_IDLE: begin
            w_busy = 1'b0;
            if (bus.start) w_next = S_LOAD;
         end
         S_LOAD: begin
            w_ready = 1'b1;
            if (w_end_msg) w_next = S_PARITY;
         end
         S_PARITY: begin
            if (r_par_cnt == PAR_LAST) w_next = S_FIN;
         end
         S_FIN: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lfsr     <= '0;
         r_count    <= 6'd0;
         r_par_cnt  <= '0;
         r_cw       <= 8'h00;
         r_valid    <= 1'b0;
         r_done     <= 1'b0;
`ifdef RS_ENC_OVERFLOW_EN
         r_overflow <= 1'b0;
`endif
      end else begin
         // done is registered so it lands the cycle after the last parity byte
         r_done  <= (r_state == S_FIN);
         r_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_lfsr     <= '0;
                  r_count    <= 6'd0;
                  r_par_cnt  <= '0;
`ifdef RS_ENC_OVERFLOW_EN
                  r_overflow <= 1'b0;
`endif
               end
            end
            S_LOAD: begin
               if (w_accept) begin
                  r_lfsr  <= w_lfsr_upd;
                  r_cw    <= bus.msg_in;
                  r_valid <= 1'b1;
                  if (r_count != MSG_LAST) r_count <= r_count + 6'd1;
`ifdef RS_ENC_OVERFLOW_EN
                  if (w_forced) r_overflow <= 1'b1;
`endif
               end
            end
            S_PARITY: begin
               // remainder drains MSB first; zero-fill keeps the shift clean
               r_cw      <= r_lfsr[NSYM-1];
               r_valid   <= 1'b1;
               r_lfsr    <= {r_lfsr[NSYM-2:0], 8'h00};
               r_par_cnt <= r_par_cnt + 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.ready_in     = w_ready;
   assign bus.busy         = w_busy;
   assign bus.codeword_out = r_cw;
   assign bus.valid_out    = r_valid;
   assign bus.done         = r_done;
`ifdef RS_ENC_OVERFLOW_EN
   assign bus.overflow     = r_overflow;
`endif

endmodule

// File: tb/tb_rs_encode_stream.sv
// tb/tb_rs_encode_stream.sv - scoreboard bench for rs_encode_stream
module tb_rs_encode_stream;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   rs_encode_stream_if bus();

   rs_encode_stream dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int         tests_run = 0;
   int         tests_failed = 0;
   logic [7:0] exp_q[$];
   logic [7:0] msg_buf[$];
   int         out_cnt = 0;
   int         done_cnt = 0;
   logic       prev_valid = 1'b0;
   logic [7:0] mon_exp;
   bit         use_ref = 1'b0;
   logic [7:0] ref_par[0:6];
   logic [7:0] exp_t[0:255];
   int         log_t[0:255];
   logic [7:0] g_msb[0:7];

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      if (a == 8'h00 || b == 8'h00) return 8'h00;
      return exp_t[(log_t[a] + log_t[b]) % 255];
   endfunction

   task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      tests_run++;
      assert (obs === expv) else begin
         tests_failed++;
         $error("FAIL %s observed=%02h expected=%02h", tag, obs, expv);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int expv);
      tests_run++;
      assert (obs == expv) else begin
         tests_failed++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // long division of msg*x^7 by the monic generator, MSB-first
   task automatic push_parity();
      logic [7:0] wb[0:31];
      logic [7:0] c;
      int         n;
      n = msg_buf.size();
      for (int i = 0; i < 32; i++) wb[i] = 8'h00;
      for (int i = 0; i < n; i++) wb[i] = msg_buf[i];
      for (int i = 0; i < n; i++) begin
         c = wb[i];
         for (int j = 1; j < 8; j++) wb[i+j] = wb[i+j] ^ gmul(g_msb[j], c);
      end
      for (int j = 0; j < 7; j++) exp_q.push_back(use_ref ? ref_par[j] : wb[n+j]);
   endtask

   task automatic do_start();
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
   endtask

   task automatic put_byte(input logic [7:0] b, input logic l);
      @(negedge clk);
      bus.msg_in   = b;
      bus.valid_in = 1'b1;
      bus.last_in  = l;
      check8("ready_in_load", bus.ready_in, 8'h01);
      exp_q.push_back(b);
      msg_buf.push_back(b);
      if (l || msg_buf.size() == 25) push_parity();
      @(posedge clk);
      #1;
      bus.valid_in = 1'b0;
      bus.last_in  = 1'b0;
   endtask

   task automatic wait_done(input int len);
      int d0;
      d0 = done_cnt;
      for (int i = 0; i < 60 && done_cnt == d0; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      #1;
      check_int("done_pulses", done_cnt, d0 + 1);
      check_int("valid_out_count", out_cnt, len + 7);
      check_int("scoreboard_empty", exp_q.size(), 0);
      check8("busy_after_done", bus.busy, 8'h00);
      out_cnt = 0;
      msg_buf.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check8({tag, "_ready_in"}, bus.ready_in, 8'h00);
      check8({tag, "_codeword_out"}, bus.codeword_out, 8'h00);
      check8({tag, "_valid_out"}, bus.valid_out, 8'h00);
      check8({tag, "_done"}, bus.done, 8'h00);
      check8({tag, "_busy"}, bus.busy, 8'h00);
`ifdef RS_ENC_OVERFLOW_EN
      check8({tag, "_overflow"}, bus.overflow, 8'h00);
`endif
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.valid_out) begin
            out_cnt++;
            tests_run++;
            assert (exp_q.size() != 0) else begin
               tests_failed++;
               $error("FAIL unexpected_byte observed=%02h expected=none", bus.codeword_out);
            end
            if (exp_q.size() != 0) begin
               mon_exp = exp_q.pop_front();
               tests_run++;
               assert (bus.codeword_out === mon_exp) else begin
                  tests_failed++;
                  $error("FAIL codeword_out observed=%02h expected=%02h", bus.codeword_out, mon_exp);
               end
            end
         end
         if (bus.done) begin
            done_cnt++;
            tests_run++;
            assert (prev_valid === 1'b1 && bus.valid_out === 1'b0) else begin
               tests_failed++;
               $error("FAIL done_timing observed=prev_valid:%b valid:%b expected=1,0", prev_valid, bus.valid_out);
            end
         end
         prev_valid = bus.valid_out;
      end else begin
         prev_valid = 1'b0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [8:0] x;
      logic [7:0] r;
      x = 9'h001;
      for (int i = 0; i < 255; i++) begin
         exp_t[i] = x[7:0];
         log_t[x[7:0]] = i;
         x = x << 1;
         if (x[8]) x = x ^ 9'h11D;
      end
      exp_t[255] = 8'h01;
      log_t[0] = 0;
      for (int k = 0; k < 8; k++) g_msb[k] = 8'h00;
      g_msb[0] = 8'h01;
      for (int i = 0; i < 7; i++) begin
         for (int k = i + 1; k >= 1; k--) g_msb[k] = g_msb[k] ^ gmul(g_msb[k-1], exp_t[i]);
      end
      ref_par = '{8'h7F, 8'h7A, 8'h9A, 8'hA4, 8'h0B, 8'h44, 8'h75};

      bus.start = 1'b0;
      bus.msg_in = 8'h00;
      bus.valid_in = 1'b0;
      bus.last_in = 1'b0;

      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // single byte 01 against the known vector
      use_ref = 1'b1;
      do_start();
      put_byte(8'h01, 1'b1);
      wait_done(1);
      use_ref = 1'b0;

      // five zero bytes
      do_start();
      for (int i = 0; i < 5; i++) put_byte(8'h00, i == 4);
      wait_done(5);

      // idle cycles after start, then a gap inside the message
      do_start();
      repeat (3) @(negedge clk);
      put_byte(8'h01, 1'b1);
      wait_done(1);
      do_start();
      put_byte(8'h01, 1'b0);
      repeat (2) @(negedge clk);
      put_byte(8'h00, 1'b1);
      wait_done(2);

      // 25 random bytes without last_in: forced end
      do_start();
      for (int i = 0; i < 25; i++) put_byte(8'($urandom_range(0, 255)), 1'b0);
      @(negedge clk);
      bus.msg_in = 8'hAA;
      bus.valid_in = 1'b1;
      check8("ready_in_after_forced_end", bus.ready_in, 8'h00);
      @(posedge clk);
      #1 bus.valid_in = 1'b0;
      wait_done(25);
`ifdef RS_ENC_OVERFLOW_EN
      check8("overflow_set", bus.overflow, 8'h01);
`endif

      // start pulsed during PARITY is ignored
      do_start();
`ifdef RS_ENC_OVERFLOW_EN
      check8("overflow_cleared", bus.overflow, 8'h00);
`endif
      put_byte(8'h55, 1'b0);
      put_byte(8'hA3, 1'b1);
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      wait_done(2);
      repeat (3) @(negedge clk);
      check8("start_in_parity_ignored", bus.busy, 8'h00);
      do_start();
      for (int i = 0; i < 3; i++) begin
         r = 8'($urandom_range(0, 255));
         put_byte(r, i == 2);
      end
      wait_done(3);

      // reset during the third message byte
      do_start();
      put_byte(8'h11, 1'b0);
      put_byte(8'h22, 1'b0);
      @(negedge clk);
      bus.msg_in = 8'h33;
      bus.valid_in = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      bus.valid_in = 1'b0;
      exp_q.delete();
      msg_buf.delete();
      out_cnt = 0;
      repeat (3) @(negedge clk);
      check8("midreset_valid_held", bus.valid_out, 8'h00);
      rst_n = 1'b1;
      @(negedge clk);
      use_ref = 1'b1;
      do_start();
      put_byte(8'h01, 1'b1);
      wait_done(1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
